// File: rtl/net_msgs_pkg.sv
// net_msgs_pkg
//   Shared network message definitions used by the router and its endpoints.
//   Header layout (12 bits): dest[11:10], src[9:8], opaque[7:0].
//   Also carries the endpoint error-flag bit indices.
package net_msgs_pkg;

  localparam int NET_DEST_NBITS   = 2;
  localparam int NET_SRC_NBITS    = 2;
  localparam int NET_OPAQUE_NBITS = 8;
  localparam int NET_HDR_NBITS    = NET_DEST_NBITS + NET_SRC_NBITS + NET_OPAQUE_NBITS;

  typedef struct packed {
    logic [NET_DEST_NBITS-1:0]   dest;
    logic [NET_SRC_NBITS-1:0]    src;
    logic [NET_OPAQUE_NBITS-1:0] opaque;
  } net_hdr_t;

  // Endpoint sticky error flag bit positions
  localparam int NET_ERR_MISROUTE = 0;
  localparam int NET_ERR_SPURIOUS = 1;
  localparam int NET_ERR_NBITS    = 2;

endpackage

// File: rtl/net_endpoint_tag_table.sv
// net_endpoint_tag_table
//   Small associative table of in-flight opaque tags for the endpoint adapter.
//   Only instantiated when NET_ENDPOINT_ADAPTER_TAG_CHECK_EN is defined.
//   Ports:
//     clk, reset   - clock, synchronous active-high reset (clears all entries)
//     alloc_en     - record alloc_tag in the lowest-index free entry
//     alloc_tag    - opaque to record
//     lookup_en    - search for lookup_tag; on a hit the matching entry is freed
//     lookup_tag   - opaque to search for
//     hit          - combinational: lookup_tag matches a live entry
//   Allocation and free in the same cycle always target different entries
//   (one is free, the other live), so both are honoured.
module net_endpoint_tag_table
  import net_msgs_pkg::*;
#(
  parameter int p_entries = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alloc_en,
  input  logic [NET_OPAQUE_NBITS-1:0] alloc_tag,
  input  logic                        lookup_en,
  input  logic [NET_OPAQUE_NBITS-1:0] lookup_tag,
  output logic                        hit
);

  localparam int IDX_W = (p_entries > 1) ? $clog2(p_entries) : 1;

  logic [p_entries-1:0]        valid_reg;
  logic [NET_OPAQUE_NBITS-1:0] tag_reg [p_entries];
  logic [p_entries-1:0]        match;
  logic [IDX_W-1:0]            alloc_idx;
  logic                        alloc_ok;
  logic [IDX_W-1:0]            free_idx;

  // Descending scan so the lowest qualifying index wins.
  always_comb begin
    alloc_idx = '0;
    alloc_ok  = 1'b0;
    free_idx  = '0;
    for (int i = p_entries - 1; i >= 0; i--) begin
      if (!valid_reg[i]) begin
        alloc_idx = IDX_W'(i);
        alloc_ok  = 1'b1;
      end
      if (match[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  assign hit = |match;

  genvar gi;
  generate
    for (gi = 0; gi < p_entries; gi++) begin : g_entry
      assign match[gi] = valid_reg[gi] && (tag_reg[gi] == lookup_tag);

      always_ff @(posedge clk) begin
        if (reset) begin
          valid_reg[gi] <= 1'b0;
          tag_reg[gi]   <= '0;
        end else if (alloc_en && alloc_ok && (alloc_idx == IDX_W'(gi))) begin
          valid_reg[gi] <= 1'b1;
          tag_reg[gi]   <= alloc_tag;
        end else if (lookup_en && hit && (free_idx == IDX_W'(gi))) begin
          valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/net_endpoint_adapter.sv
// net_endpoint_adapter
//   Terminal-side endpoint of the network. Builds headers for client requests
//   (src = p_router_id, opaque = rolling 8-bit tag) and injects them into the
//   router; accepts ejected messages, filters misrouted / unexpected ones and
//   hands good responses to the client. In-flight requests are bounded by
//   p_max_outstanding.
//   Optional feature: define NET_ENDPOINT_ADAPTER_TAG_CHECK_EN to match each
//   response's opaque against a table of injected tags; otherwise any
//   dest-matching response with a request outstanding is accepted.
//   Ports:
//     clk, reset                       - clock, synchronous active-high reset
//     req_dest/req_payload/req_val/req_rdy         - client request in
//     out_msg_hdr/out_msg_payload/out_val/out_rdy  - injection to router
//     in_msg_hdr/in_msg_payload/in_val/in_rdy      - ejection from router
//     resp_src/resp_opaque/resp_payload/resp_val/resp_rdy - response to client
//     err                              - sticky [0] misroute, [1] spurious
module net_endpoint_adapter
  import net_msgs_pkg::*;
#(
  parameter int p_router_id       = 0,
  parameter int p_payload_nbits   = 32,
  parameter int p_max_outstanding = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NET_DEST_NBITS-1:0]   req_dest,
  input  logic [p_payload_nbits-1:0]  req_payload,
  input  logic                        req_val,
  output logic                        req_rdy,
  output logic [NET_HDR_NBITS-1:0]    out_msg_hdr,
  output logic [p_payload_nbits-1:0]  out_msg_payload,
  output logic                        out_val,
  input  logic                        out_rdy,
  input  logic [NET_HDR_NBITS-1:0]    in_msg_hdr,
  input  logic [p_payload_nbits-1:0]  in_msg_payload,
  input  logic                        in_val,
  output logic                        in_rdy,
  output logic [NET_SRC_NBITS-1:0]    resp_src,
  output logic [NET_OPAQUE_NBITS-1:0] resp_opaque,
  output logic [p_payload_nbits-1:0]  resp_payload,
  output logic                        resp_val,
  input  logic                        resp_rdy,
  output logic [NET_ERR_NBITS-1:0]    err
);

  localparam int OUT_W = $clog2(p_max_outstanding + 1);

  // Inject register
  net_hdr_t                    out_hdr_reg;
  logic [p_payload_nbits-1:0]  out_payload_reg;
  logic                        out_val_reg;
  logic [NET_OPAQUE_NBITS-1:0] tag_reg;

  // Eject register
  logic [NET_SRC_NBITS-1:0]    resp_src_reg;
  logic [NET_OPAQUE_NBITS-1:0] resp_opaque_reg;
  logic [p_payload_nbits-1:0]  resp_payload_reg;
  logic                        resp_val_reg;

  logic [OUT_W-1:0]            outstanding_reg;
  logic [OUT_W-1:0]            outstanding_next;
  logic [NET_ERR_NBITS-1:0]    err_reg;
  logic [NET_ERR_NBITS-1:0]    err_next;

  logic     req_xfer;
  logic     out_xfer;
  logic     in_xfer;
  logic     resp_xfer;
  net_hdr_t in_hdr;
  net_hdr_t new_hdr;
  logic     dest_ok;
  logic     credit_ok;
  logic     resp_good;

  assign in_hdr  = net_hdr_t'(in_msg_hdr);
  assign dest_ok = (in_hdr.dest == NET_DEST_NBITS'(p_router_id));

  assign req_rdy   = (!out_val_reg || out_rdy) &&
                     (outstanding_reg < OUT_W'(p_max_outstanding));
  assign in_rdy    = !resp_val_reg || resp_rdy;

  assign req_xfer  = req_val && req_rdy;
  assign out_xfer  = out_val_reg && out_rdy;
  assign in_xfer   = in_val && in_rdy;
  assign resp_xfer = resp_val_reg && resp_rdy;

  assign new_hdr.dest   = req_dest;
  assign new_hdr.src    = NET_SRC_NBITS'(p_router_id);
  assign new_hdr.opaque = tag_reg;

`ifdef NET_ENDPOINT_ADAPTER_TAG_CHECK_EN
  logic tag_hit;

  net_endpoint_tag_table #(
    .p_entries (p_max_outstanding)
  ) u_tag_table (
    .clk        (clk),
    .reset      (reset),
    .alloc_en   (req_xfer),
    .alloc_tag  (tag_reg),
    .lookup_en  (in_xfer && dest_ok),
    .lookup_tag (in_hdr.opaque),
    .hit        (tag_hit)
  );

  // Live entries equal outstanding requests, so a hit implies credit.
  assign credit_ok = tag_hit;
`else
  // A request accepted this very cycle counts as outstanding for the check.
  assign credit_ok = (outstanding_reg != '0) || req_xfer;
`endif

  assign resp_good = in_xfer && dest_ok && credit_ok;

  always_comb begin
    outstanding_next = outstanding_reg;
    case ({req_xfer, resp_good})
      2'b10:   outstanding_next = outstanding_reg + 1'b1;
      2'b01:   outstanding_next = outstanding_reg - 1'b1;
      default: outstanding_next = outstanding_reg;
    endcase
  end

  always_comb begin
    err_next = err_reg;
    if (in_xfer && !dest_ok) begin
      err_next[NET_ERR_MISROUTE] = 1'b1;
    end
    if (in_xfer && dest_ok && !credit_ok) begin
      err_next[NET_ERR_SPURIOUS] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_hdr_reg      <= '0;
      out_payload_reg  <= '0;
      out_val_reg      <= 1'b0;
      tag_reg          <= '0;
      resp_src_reg     <= '0;
      resp_opaque_reg  <= '0;
      resp_payload_reg <= '0;
      resp_val_reg     <= 1'b0;
      outstanding_reg  <= '0;
      err_reg          <= '0;
    end else begin
      if (req_xfer) begin
        out_hdr_reg     <= new_hdr;
        out_payload_reg <= req_payload;
        out_val_reg     <= 1'b1;
        tag_reg         <= tag_reg + 1'b1;  // wraps 255 -> 0
      end else if (out_xfer) begin
        out_val_reg <= 1'b0;
      end

      if (resp_good) begin
        resp_src_reg     <= in_hdr.src;
        resp_opaque_reg  <= in_hdr.opaque;
        resp_payload_reg <= in_msg_payload;
        resp_val_reg     <= 1'b1;
      end else if (resp_xfer) begin
        resp_val_reg <= 1'b0;
      end

      outstanding_reg <= outstanding_next;
      err_reg         <= err_next;
    end
  end

  assign out_msg_hdr     = out_hdr_reg;
  assign out_msg_payload = out_payload_reg;
  assign out_val         = out_val_reg;
  assign resp_src        = resp_src_reg;
  assign resp_opaque     = resp_opaque_reg;
  assign resp_payload    = resp_payload_reg;
  assign resp_val        = resp_val_reg;
  assign err             = err_reg;

endmodule

// File: doc/net_endpoint_adapter.md
Name: net_endpoint_adapter

Overview:
Network endpoint adapter: the terminal-side counterpart of the router input port.
- Inject path: takes client requests (dest + payload) and builds net_hdr_t messages with src = own router id and opaque = a rolling 8-bit tag. Injects them into the router through a val/rdy handshake.
- Eject path: accepts network messages arriving at this terminal, checks them, and hands responses to the client.
- Bounds the number of in-flight requests with an outstanding-count credit limit.

Parameters:
- p_router_id, 0, this terminal's id; 2 bits, range 0-3.
- p_payload_nbits, 32, payload width.
- p_max_outstanding, 4, maximum requests accepted but not yet answered; range 1-8.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_dest  in  2  destination terminal of the client request
- req_payload  in  p_payload_nbits  request payload
- req_val  in  1  request valid
- req_rdy  out  1  request ready
- out_msg_hdr  out  net_hdr_t (12)  header to router: dest[11:10], src[9:8], opaque[7:0]
- out_msg_payload  out  p_payload_nbits  payload to router
- out_val  out  1  injection valid
- out_rdy  in  1  router input-queue ready
- in_msg_hdr  in  net_hdr_t (12)  header from router output
- in_msg_payload  in  p_payload_nbits  payload from router
- in_val  in  1  ejection valid
- in_rdy  out  1  ejection ready
- resp_src  out  2  source terminal of the response
- resp_opaque  out  8  opaque tag of the response
- resp_payload  out  p_payload_nbits  response payload
- resp_val  out  1  response valid
- resp_rdy  in  1  client ready
- err  out  2  sticky error flags: [0] misroute, [1] spurious/unknown response

Behaviour:
- Handshakes: a transfer occurs in any cycle where val && rdy. Once asserted, val is held and msg stays stable until the transfer.
- Reset values: out_val=0, resp_val=0, tag counter=0, outstanding=0, err=0; out/resp message registers = 0.
- Reset mid-operation drops all buffered messages and clears all counts.
- Inject register (one entry):
  - req_rdy = (!out_val || out_rdy) && (outstanding < p_max_outstanding).
  - On a req transfer in cycle N: register dest=req_dest, src=p_router_id, opaque=tag, payload. out_val=1 from cycle N+1.
  - tag increments on each req transfer and wraps 255->0.
  - Back-to-back injection at full throughput while out_rdy=1.
- Outstanding counter:
  - Width $clog2(p_max_outstanding+1).
  - +1 on req transfer; -1 on an accepted good response (defined below).
  - Both in the same cycle: unchanged.
  - Never exceeds p_max_outstanding; never underflows.
- Eject register (one entry):
  - in_rdy = !resp_val || resp_rdy. The register is always drained, including for bad messages, so the network never blocks.
  - On an in transfer in cycle N:
    - If in_msg_hdr.dest != p_router_id: drop the message, set err[0]; no response.
    - Else if outstanding == 0 (with the inclusion of simultaneous increments): drop, set err[1].
    - Else: good response. Load the resp register; resp_val=1 at N+1.
  - Same-cycle resp transfer and new in transfer: the register is reloaded, giving a full-throughput pipeline.
- err bits stay set until reset.

Optional Feature:
- Macro: NET_ENDPOINT_ADAPTER_TAG_CHECK_EN.
- Defined:
  - A p_max_outstanding-entry table records the opaque of each injected request on its req transfer.
  - A response whose opaque matches a live entry frees that entry and counts as good.
  - A response with no match is dropped and sets err[1].
  - Lookup and free take effect in the same cycle as the in transfer. A same-cycle allocate and free of different entries are both honoured.
- Undefined: no table. Any dest-matching response with outstanding > 0 counts as good, regardless of opaque.

Decomposition:
- net_hdr_t and field widths come from the shared net-msgs package.
- Add to that package: the error bit-index constants (NET_ERR_MISROUTE=0, NET_ERR_SPURIOUS=1) and the opaque width constant (8).
- One sub-module, net_endpoint_tag_table, used only under the macro. It provides alloc/lookup/free over a valid-bit + 8-bit tag array with a lowest-free-index allocator.

Test Plan:
- Single request, id=1: req dest=2, payload=0xDEADBEEF -> next cycle out_val=1, hdr {dest=2, src=1, opaque=0x00}, payload 0xDEADBEEF. Return the message with dest=1 -> resp_val next cycle, opaque 0x00, outstanding back to 0.
- Credit limit, p_max_outstanding=4: 5 requests with out_rdy=1 and no responses -> exactly 4 injected with opaques 0-3; req_rdy=0 afterward. One response -> req_rdy=1 the following cycle.
- Backpressure: out_rdy=0 for 3 cycles with out_val=1 -> hdr/payload held stable, req_rdy=0. Release -> injected, and a new req is accepted the same cycle.
- Tag wrap: 257 request/response pairs -> the 257th injected opaque = 0x00 (wrapped after 0xFF).
- Errors: in msg with dest=3 at id=1 -> in_rdy=1, no resp, err=2'b01. Dest=1 response with outstanding=0 -> err=2'b11. Reset -> err=0.
- Macro on: inject opaque 0x05, reply with opaque 0x09 -> dropped, err[1]=1, outstanding still 1. Then reply with opaque 0x05 -> resp_val=1, outstanding 0.
